// File: rtl/isqrt_pipelined.sv
// Fully pipelined 32-bit unsigned integer square root, y = floor(sqrt(x)).
// Fixed latency of n_pipe_stages cycles, one argument per clock, no back-pressure.
module isqrt_pipelined #(
  parameter int unsigned n_pipe_stages = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y
);

  localparam int unsigned NumIter       = 16;
  localparam int unsigned ItersPerStage = NumIter / n_pipe_stages;
  localparam int unsigned LastStage     = n_pipe_stages - 1;
  localparam bit          LegalStages   = (n_pipe_stages == 1) || (n_pipe_stages == 2) ||
                                          (n_pipe_stages == 4) || (n_pipe_stages == 8) ||
                                          (n_pipe_stages == 16);

  if (!LegalStages) begin : g_bad_stages
    $error("isqrt_pipelined: n_pipe_stages must be 1, 2, 4, 8 or 16");
  end

  for (genvar s = 0; s < n_pipe_stages; s++) begin : g_stage
    logic        vld_in;
    logic [31:0] rem_in;
    logic [31:0] root_in;
    logic [31:0] rem_c;
    logic [31:0] root_c;
    logic [31:0] bit_c;
    logic [31:0] trial_c;
    logic        vld_q;
    logic [31:0] rem_q;
    logic [31:0] root_q;

    if (s == 0) begin : g_first
      assign vld_in  = x_vld;
      assign rem_in  = x;
      assign root_in = '0;
    end else begin : g_next
      assign vld_in  = g_stage[s-1].vld_q;
      assign rem_in  = g_stage[s-1].rem_q;
      assign root_in = g_stage[s-1].root_q;
    end

    // bit is fixed by the absolute iteration index, so it folds to a constant per iteration.
    always_comb begin
      rem_c   = rem_in;
      root_c  = root_in;
      bit_c   = '0;
      trial_c = '0;
      for (int unsigned i = 0; i < ItersPerStage; i++) begin
        bit_c   = 32'h4000_0000 >> (2 * (s * ItersPerStage + i));
        trial_c = root_c + bit_c;
        if (rem_c >= trial_c) begin
          rem_c  = rem_c - trial_c;
          root_c = (root_c >> 1) + bit_c;
        end else begin
          root_c = root_c >> 1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= vld_in;
      end
    end

    // Datapath loads every cycle; only the valid bit carries meaning across reset.
    always_ff @(posedge clk) begin
      rem_q  <= rem_c;
      root_q <= root_c;
    end
  end

  assign y_vld = g_stage[LastStage].vld_q;
  assign y     = g_stage[LastStage].root_q[15:0];

  // A finished root fits in 16 bits and leaves a remainder x - y^2 no larger than 2y.
  root_result_ok: assert property (@(posedge clk) disable iff (!rst)
    y_vld |-> ((g_stage[LastStage].root_q[31:16] == 16'h0000) &&
               (g_stage[LastStage].rem_q <= {g_stage[LastStage].root_q[30:0], 1'b0})));

endmodule

// File: tb/tb_isqrt_pipelined.sv
// Scoreboard bench for isqrt_pipelined: one instance per legal depth plus a depth-4 twin.
module tb_isqrt_pipelined;

  localparam int NumDut = 6;

  logic        clk;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;
  logic [31:0] x_tw;
  logic        yv [NumDut];
  logic [15:0] yy [NumDut];

  int          lat [NumDut] = '{1, 2, 4, 8, 16, 4};
  logic [16:0] sb [NumDut][$];
  int          total = 0;
  int          bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    isqrt_pipelined #(.n_pipe_stages(1 << g)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld),
      .x     (x),
      .y_vld (yv[g]),
      .y     (yy[g])
    );
  end

  isqrt_pipelined #(.n_pipe_stages(4)) u_twin (
    .clk   (clk),
    .rst   (rst),
    .x_vld (x_vld),
    .x     (x_tw),
    .y_vld (yv[5]),
    .y     (yy[5])
  );

  function automatic logic [15:0] isqrt_ref(input logic [31:0] v);
    logic [15:0] r;
    logic [15:0] t;
    logic [63:0] sq;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t  = r | (16'h0001 << b);
      sq = {48'h0, t} * {48'h0, t};
      if (sq <= {32'h0, v}) r = t;
    end
    return r;
  endfunction

  task automatic check_idle(input string tag);
    for (int d = 0; d < NumDut; d++) begin
      total++;
      assert (yv[d] === 1'b0) else begin
        bad++;
        $error("FAIL %s dut%0d y_vld got=%b want=0", tag, d, yv[d]);
      end
    end
  endtask

  task automatic do_reset();
    x_vld = 1'b0;
    rst   = 1'b0;
    #1;
    check_idle("reset_async");
    @(posedge clk);
    #1;
    check_idle("reset_held");
    rst = 1'b1;
    for (int d = 0; d < NumDut; d++) begin
      sb[d].delete();
      repeat (lat[d] - 1) sb[d].push_back(17'h0);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] xa, input logic [31:0] xb);
    logic [16:0] e;
    x_vld = v;
    x     = xa;
    x_tw  = xb;
    for (int d = 0; d < NumDut; d++)
      sb[d].push_back({v, isqrt_ref((d == 5) ? xb : xa)});
    @(posedge clk);
    #1;
    for (int d = 0; d < NumDut; d++) begin
      e = sb[d].pop_front();
      total++;
      assert (yv[d] === e[16]) else begin
        bad++;
        $error("FAIL y_vld dut%0d got=%b want=%b", d, yv[d], e[16]);
      end
      if (e[16]) begin
        total++;
        assert (yy[d] === e[15:0]) else begin
          bad++;
          $error("FAIL y dut%0d got=%h want=%h", d, yy[d], e[15:0]);
        end
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [31:0] xa);
    drive(v, xa, xa);
  endtask

  task automatic flush();
    repeat (20) cycle(1'b0, 32'h0);
  endtask

  logic [31:0] corners [7] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd15, 32'd16};
  logic [31:0] extremes [4] = '{32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000, 32'h4000_0000};

  initial begin
    rst   = 1'b0;
    x_vld = 1'b0;
    x     = '0;
    x_tw  = '0;
    do_reset();

    // Corner values, each isolated by a bubble.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, corners[i]);
      cycle(1'b0, 32'h0);
    end
    flush();

    // Extremes back to back.
    for (int i = 0; i < 4; i++) cycle(1'b1, extremes[i]);
    flush();

    // Dense random stream, then random stream with gaps.
    for (int i = 0; i < 1000; i++)
      cycle(1'b1, (i % 3 == 0) ? $urandom_range(0, 1000) : $urandom());
    for (int i = 0; i < 1000; i++)
      cycle($urandom_range(0, 2) != 0, $urandom());
    flush();

    // Initiator pattern: second argument lands in the cycle the depth-4 result returns.
    cycle(1'b1, 32'd9);
    repeat (3) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'd25);
    flush();

    // Lockstep: the twin gets a different argument in the same cycle.
    drive(1'b1, 32'd16, 32'd81);
    flush();

    // Reset with operations in flight.
    cycle(1'b1, 32'd100);
    cycle(1'b1, 32'd200);
    cycle(1'b1, 32'd300);
    cycle(1'b0, 32'h0);
    do_reset();
    repeat (3) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'd49);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
